// File: rtl/pkt_fifo_backpressure.sv
// Show-ahead packet FIFO: stores data plus sop/eop/empty sideband per beat,
// exposes a fill-level status register and a registered almost_full flag.
module pkt_fifo_backpressure #(
    parameter int SYMBOLS_PER_BEAT = 64,
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int FIFO_DEPTH       = 1024,
    parameter int FULL_LEVEL       = 950,
    localparam int DATA_W  = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL,
    localparam int EMPTY_W = (SYMBOLS_PER_BEAT > 1) ? $clog2(SYMBOLS_PER_BEAT) : 1
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    input  logic [EMPTY_W-1:0] in_empty,

    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,

    input  logic               csr_address,
    input  logic               csr_read,
    input  logic               csr_write,
    input  logic [31:0]        csr_writedata,
    output logic [31:0]        csr_readdata,

    output logic               almost_full
);

    localparam int ADDR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FILL_W  = ADDR_W + 1;
    localparam int ENTRY_W = DATA_W + 2 + EMPTY_W;

    localparam logic [FILL_W-1:0] DEPTH_FILL    = FILL_W'(FIFO_DEPTH);
    localparam logic [31:0]       FULL_LEVEL_U  = 32'(FULL_LEVEL);

    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];

    logic [ADDR_W-1:0]  r_wrPtr;
    logic [ADDR_W-1:0]  r_rdPtr;
    logic [FILL_W-1:0]  r_fill;
    logic [31:0]        r_csrReadData;
    logic               r_almostFull;

    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_wrEntry;
    logic [ENTRY_W-1:0] w_headEntry;
    logic [31:0]        w_fillExt;
    logic               w_unusedCsr;

    // Handshake flags come straight from the registered fill so in_ready never
    // depends on out_ready; a full FIFO refuses a write even while being read.
    assign in_ready  = (r_fill != DEPTH_FILL);
    assign out_valid = (r_fill != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_wrEntry   = {in_startofpacket, in_endofpacket, in_empty, in_data};
    assign w_headEntry = r_mem[r_rdPtr];

    assign out_data          = w_headEntry[DATA_W-1:0];
    assign out_empty         = w_headEntry[DATA_W +: EMPTY_W];
    assign out_endofpacket   = w_headEntry[DATA_W + EMPTY_W];
    assign out_startofpacket = w_headEntry[DATA_W + EMPTY_W + 1];

    assign w_fillExt   = {{(32 - FILL_W){1'b0}}, r_fill};
    assign w_unusedCsr = ^{csr_write, csr_writedata};

    // Storage is deliberately left unreset; stale entries are unreachable once
    // the pointers and fill are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_wrEntry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FILL_W'(1);
                2'b01:   r_fill <= r_fill - FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Status register and threshold flag both sample the pre-edge fill,
    // so they trail the FIFO state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csrReadData <= '0;
            r_almostFull  <= 1'b0;
        end else begin
            r_almostFull <= (w_fillExt >= FULL_LEVEL_U);
            if (csr_read) begin
                r_csrReadData <= (csr_address == 1'b0) ? w_fillExt : 32'd0;
            end
        end
    end

    assign csr_readdata = r_csrReadData;
    assign almost_full  = r_almostFull;

endmodule

// File: tb/tb_pkt_fifo_backpressure.sv
// Directed self-checking bench for pkt_fifo_backpressure: packet pass-through,
// full/backpressure, almost_full threshold, pointer wrap and mid-packet reset.
module tb_pkt_fifo_backpressure;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_startofpacket;
    logic         in_endofpacket;
    logic [5:0]   in_empty;
    logic [511:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_startofpacket;
    logic         out_endofpacket;
    logic [5:0]   out_empty;
    logic         csr_address;
    logic         csr_read;
    logic         csr_write;
    logic [31:0]  csr_writedata;
    logic [31:0]  csr_readdata;
    logic         almost_full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pkt_fifo_backpressure dut (
        .clk               (clk),
        .rst               (rst),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .csr_address       (csr_address),
        .csr_read          (csr_read),
        .csr_write         (csr_write),
        .csr_writedata     (csr_writedata),
        .csr_readdata      (csr_readdata),
        .almost_full       (almost_full)
    );

    // Sequence-numbered beat pattern so any reorder, drop or stray write shows up.
    function automatic logic [511:0] beatData(input int n);
        logic [31:0] s;
        s = n[31:0];
        return {8{s, ~s}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [511:0] data,
                                 input logic sop, input logic eop,
                                 input logic [5:0] empty, input logic outReady);
        in_valid         = valid;
        in_data          = data;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_empty         = empty;
        out_ready        = outReady;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst           = 1'b1;
        csr_address   = 1'b0;
        csr_read      = 1'b1;
        csr_write     = 1'b1;
        csr_writedata = 32'hDEAD_BEEF;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b0);
        tick;
        tick;
        rst = 1'b0;

        checkOutput("reset_out_valid", 512'(out_valid), 512'(0));
        checkOutput("reset_in_ready", 512'(in_ready), 512'(1));
        checkOutput("reset_almost_full", 512'(almost_full), 512'(0));
        checkOutput("reset_csr", 512'(csr_readdata), 512'(0));

        $display("[TB] three-beat packet pass-through");
        applyStimulus(1'b1, beatData(100), 1'b1, 1'b0, 6'd0, 1'b1);
        checkOutput("pkt_pre_accept_valid", 512'(out_valid), 512'(0));
        tick;
        checkOutput("pkt_b0_valid", 512'(out_valid), 512'(1));
        checkOutput("pkt_b0_data", out_data, beatData(100));
        checkOutput("pkt_b0_sop", 512'(out_startofpacket), 512'(1));
        applyStimulus(1'b1, beatData(101), 1'b0, 1'b0, 6'd0, 1'b1);
        tick;
        checkOutput("pkt_b1_data", out_data, beatData(101));
        checkOutput("pkt_b1_sop", 512'(out_startofpacket), 512'(0));
        checkOutput("pkt_b1_eop", 512'(out_endofpacket), 512'(0));
        applyStimulus(1'b1, beatData(102), 1'b0, 1'b1, 6'd5, 1'b1);
        tick;
        checkOutput("pkt_b2_data", out_data, beatData(102));
        checkOutput("pkt_b2_eop", 512'(out_endofpacket), 512'(1));
        checkOutput("pkt_b2_empty", 512'(out_empty), 512'(5));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b1);
        tick;
        checkOutput("pkt_drained_valid", 512'(out_valid), 512'(0));

        $display("[TB] fill to full with out_ready low");
        for (int i = 0; i < 1024; i++) begin
            applyStimulus(1'b1, beatData(i), (i == 0), 1'b0, 6'd0, 1'b0);
            tick;
            if (i == 99)  checkOutput("fill_csr_lag", 512'(csr_readdata), 512'(99));
            if (i == 949) checkOutput("af_at_950_push", 512'(almost_full), 512'(0));
            if (i == 950) checkOutput("af_after_950", 512'(almost_full), 512'(1));
        end
        checkOutput("full_in_ready", 512'(in_ready), 512'(0));
        checkOutput("full_csr_lag", 512'(csr_readdata), 512'(1023));
        applyStimulus(1'b1, beatData(9999), 1'b0, 1'b0, 6'd0, 1'b0);
        tick;
        checkOutput("full_csr", 512'(csr_readdata), 512'(1024));
        checkOutput("full_head_data", out_data, beatData(0));
        checkOutput("full_head_sop", 512'(out_startofpacket), 512'(1));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b0);
        tick;
        checkOutput("full_reject_csr", 512'(csr_readdata), 512'(1024));

        $display("[TB] write and read together while full");
        applyStimulus(1'b1, beatData(8888), 1'b0, 1'b0, 6'd0, 1'b1);
        tick;
        checkOutput("fullrw_in_ready", 512'(in_ready), 512'(1));
        checkOutput("fullrw_head", out_data, beatData(1));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b0);
        tick;
        checkOutput("fullrw_csr", 512'(csr_readdata), 512'(1023));

        $display("[TB] drain through almost_full threshold");
        for (int k = 1; k <= 73; k++) begin
            checkOutput("drain_order", out_data, beatData(k));
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b1);
            tick;
        end
        checkOutput("af_at_950", 512'(almost_full), 512'(1));
        checkOutput("drain_head_74", out_data, beatData(74));
        tick;
        checkOutput("af_pop_to_949", 512'(almost_full), 512'(1));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b0);
        tick;
        checkOutput("af_clear_949", 512'(almost_full), 512'(0));
        checkOutput("csr_949", 512'(csr_readdata), 512'(949));
        for (int k = 75; k <= 523; k++) begin
            checkOutput("drain_order", out_data, beatData(k));
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b1);
            tick;
        end

        $display("[TB] steady push/pop at fill 500 across pointer wrap");
        for (int j = 0; j < 2000; j++) begin
            applyStimulus(1'b1, beatData(1024 + j), 1'b0, 1'b0, 6'd0, 1'b1);
            checkOutput("wrap_order", out_data, beatData(524 + j));
            tick;
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b0);
        tick;
        checkOutput("wrap_fill_500", 512'(csr_readdata), 512'(500));
        checkOutput("wrap_head", out_data, beatData(2524));

        $display("[TB] csr address 1 and hold, then mid-packet reset");
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, beatData(20000 + i), (i == 0), 1'b0, 6'd0, 1'b0);
            tick;
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b0);
        csr_address = 1'b1;
        tick;
        checkOutput("csr_addr1", 512'(csr_readdata), 512'(0));
        csr_read = 1'b0;
        csr_address = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b1);
        tick;
        tick;
        checkOutput("csr_hold", 512'(csr_readdata), 512'(0));
        checkOutput("csr_hold_head", out_data, beatData(20002));
        csr_read = 1'b1;
        applyStimulus(1'b1, beatData(20010), 1'b0, 1'b0, 6'd0, 1'b0);
        tick;
        applyStimulus(1'b1, beatData(20011), 1'b0, 1'b0, 6'd0, 1'b0);
        tick;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b0);
        tick;
        checkOutput("ten_stored_csr", 512'(csr_readdata), 512'(10));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checkOutput("midrst_out_valid", 512'(out_valid), 512'(0));
        checkOutput("midrst_csr", 512'(csr_readdata), 512'(0));
        checkOutput("midrst_af", 512'(almost_full), 512'(0));
        checkOutput("midrst_in_ready", 512'(in_ready), 512'(1));
        applyStimulus(1'b1, beatData(30000), 1'b1, 1'b1, 6'd3, 1'b0);
        tick;
        checkOutput("postrst_data", out_data, beatData(30000));
        checkOutput("postrst_empty", 512'(out_empty), 512'(3));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 6'd0, 1'b1);
        tick;
        checkOutput("postrst_drained", 512'(out_valid), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
